// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 32-bit words and streams them into instruction memory.
// Optional feature macro: ENC_JUMP_CHECK_EN (rejects j targets outside instruction memory).
module instr_encoder_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_ftn,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [5:0]        err_op,
    output logic              wrapped,
    output logic [ADDR_W:0]   count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] STEP_EXT = (ADDR_W + 1)'(ADDR_STEP);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] addr;
    logic              accept_c;
    logic              legal_c;
    logic [31:0]       word_c;
    logic [ADDR_W:0]   addr_sum_c;
    logic [CNT_W-1:0]  count_inc_c;

    assign accept_c    = in_valid & in_ready;
    assign addr_sum_c  = {1'b0, addr} + STEP_EXT;
    assign count_inc_c = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);

    // Opcode-directed field packing; unknown opcodes are flagged illegal.
    always_comb begin
        legal_c = 1'b1;
        word_c  = 32'd0;
        case (in_op)
            6'b000000, 6'b001000:
                word_c = {in_op, in_rs, in_rt, in_rd, in_shamt, in_ftn};
            6'b000001, 6'b001001, 6'b000010, 6'b000011,
            6'b000110, 6'b001010, 6'b000111:
                word_c = {in_op, in_rs, in_rt, in_imm};
            6'b101010:
                word_c = {in_op, 5'd0, in_rt, in_imm};
            6'b000100: begin
                word_c = {in_op, in_target};
`ifdef ENC_JUMP_CHECK_EN
                if ((in_target >> ADDR_W) != 26'd0) begin
                    legal_c = 1'b0;
                end
`else
`endif
            end
            default:
                legal_c = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  if (accept_c && in_last) state_next = S_FLUSH;
            S_FLUSH: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and registered status; the write register drains every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 32'd0;
            err      <= 1'b0;
            err_op   <= 6'd0;
            wrapped  <= 1'b0;
            count    <= '0;
        end else begin
            im_we    <= 1'b0;
            in_ready <= (state_next == S_LOAD);
            busy     <= (state_next != S_IDLE);
            done     <= (state_next == S_DONE);
            if (state == S_IDLE && start) begin
                addr    <= start_addr;
                err     <= 1'b0;
                err_op  <= 6'd0;
                wrapped <= 1'b0;
                count   <= '0;
            end
            if (accept_c) begin
                if (legal_c) begin
                    im_we    <= 1'b1;
                    im_addr  <= addr;
                    im_wdata <= word_c;
                    addr     <= addr_sum_c[ADDR_W-1:0];
                    count    <= count_inc_c;
                    if (addr_sum_c[ADDR_W]) begin
                        wrapped <= 1'b1;
                    end
                end else begin
                    err <= 1'b1;
                    if (!err) begin
                        err_op <= in_op;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: expected writes and status probes are queued by
// the stimulus and consumed by a monitor sampling on the falling edge.
module tb_instr_encoder_loader;

    localparam int S_WE    = 0;
    localparam int S_BUSY  = 1;
    localparam int S_DONE  = 2;
    localparam int S_ERR   = 3;
    localparam int S_ERROP = 4;
    localparam int S_WRAP  = 5;
    localparam int S_COUNT = 6;
    localparam int S_READY = 7;
    localparam int S_SBQ   = 8;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          sel;
        logic [31:0] exp;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  start_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [5:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [5:0]  in_ftn;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [5:0]  err_op;
    logic        wrapped;
    logic [8:0]  count;

    wr_t  sb[$];
    req_t rq[$];
    logic [7:0] exp_addr;
    int checks = 0;
    int failures = 0;

    instr_encoder_loader #(.ADDR_W(8), .ADDR_STEP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_ftn(in_ftn), .in_imm(in_imm), .in_target(in_target),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .busy(busy), .done(done), .err(err), .err_op(err_op),
        .wrapped(wrapped), .count(count)
    );

    always #5 clk = ~clk;

    function automatic string sname(input int sel);
        case (sel)
            S_WE:    return "im_we";
            S_BUSY:  return "busy";
            S_DONE:  return "done";
            S_ERR:   return "err";
            S_ERROP: return "err_op";
            S_WRAP:  return "wrapped";
            S_COUNT: return "count";
            S_READY: return "in_ready";
            default: return "pending_writes";
        endcase
    endfunction

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            S_WE:    return 32'(im_we);
            S_BUSY:  return 32'(busy);
            S_DONE:  return 32'(done);
            S_ERR:   return 32'(err);
            S_ERROP: return 32'(err_op);
            S_WRAP:  return 32'(wrapped);
            S_COUNT: return 32'(count);
            S_READY: return 32'(in_ready);
            default: return 32'(sb.size());
        endcase
    endfunction

    function automatic void req(input int sel, input logic [31:0] exp);
        req_t r;
        r.sel = sel;
        r.exp = exp;
        rq.push_back(r);
    endfunction

    // Monitor: every write must match the scoreboard head; queued probes are checked each cycle.
    initial begin
        wr_t  e;
        req_t r;
        logic [31:0] v;
        forever begin
            @(negedge clk);
            if (im_we === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write actual addr=%h data=%h required none", im_addr, im_wdata);
                end else begin
                    e = sb.pop_front();
                    if (im_addr !== e.addr || im_wdata !== e.data) begin
                        failures++;
                        $display("FAIL write actual addr=%h data=%h required addr=%h data=%h",
                                 im_addr, im_wdata, e.addr, e.data);
                    end
                end
            end
            while (rq.size() > 0) begin
                r = rq.pop_front();
                v = sample(r.sel);
                checks++;
                if (v !== r.exp) begin
                    failures++;
                    $display("FAIL %s actual=%h required=%h at %0t", sname(r.sel), v, r.exp, $time);
                end
            end
        end
    end

    task automatic start_session(input logic [7:0] a);
        start = 1'b1;
        start_addr = a;
        exp_addr = a;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] ftn,
                        input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                        input logic legal, input logic [31:0] word);
        wr_t w;
        in_valid = 1'b1;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_ftn = ftn; in_imm = imm; in_target = tgt;
        in_last = last;
        req(S_READY, 32'd1);
        if (legal) begin
            w.addr = exp_addr;
            w.data = word;
            sb.push_back(w);
            exp_addr = exp_addr + 8'd4;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // Called in the FLUSH cycle: DONE follows, then IDLE.
    task automatic end_session();
        req(S_BUSY, 32'd1);
        req(S_DONE, 32'd0);
        @(posedge clk); #1;
        req(S_DONE, 32'd1);
        @(posedge clk); #1;
        req(S_DONE, 32'd0);
        req(S_BUSY, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = 8'd0; in_valid = 1'b0; in_last = 1'b0;
        in_op = 6'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0;
        in_ftn = 6'd0; in_imm = 16'd0; in_target = 26'd0; exp_addr = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        req(S_WE, 0); req(S_BUSY, 0); req(S_DONE, 0); req(S_ERR, 0);
        req(S_ERROP, 0); req(S_WRAP, 0); req(S_COUNT, 0); req(S_READY, 0);
        @(posedge clk); #1;

        // single addi
        start_session(8'h10);
        send(6'b001010, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b1, 1'b1, 32'h28220005);
        end_session();
        req(S_COUNT, 1); req(S_WRAP, 0); req(S_ERR, 0);
        @(posedge clk); #1;

        // back-to-back R, lui (rs ignored), j
        start_session(8'h00);
        send(6'b000000, 5'd3, 5'd4, 5'd5, 5'd0, 6'h20, 16'h0000, 26'd0, 1'b0, 1'b1, 32'h00642820);
        send(6'b101010, 5'd31, 5'd7, 5'd0, 5'd0, 6'd0, 16'hABCD, 26'd0, 1'b0, 1'b1, 32'hA807ABCD);
        send(6'b000100, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h10, 1'b1, 1'b1, 32'h10000010);
        end_session();
        req(S_COUNT, 3);
        @(posedge clk); #1;

        // illegal ops between legal bundles; err_op keeps the first
        start_session(8'h20);
        send(6'b000111, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b0, 1'b1, 32'h1C2200FF);
        send(6'h3F, 5'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0, 1'b0, 32'd0);
        send(6'h05, 5'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0, 1'b0, 32'd0);
        send(6'b000001, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFE, 26'd0, 1'b1, 1'b1, 32'h0422FFFE);
        end_session();
        req(S_ERR, 1); req(S_ERROP, 32'h3F); req(S_COUNT, 2); req(S_WRAP, 0);
        @(posedge clk); #1;

        // address wrap
        start_session(8'hFC);
        send(6'b000011, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0, 1'b1, 32'h0C430010);
        send(6'b000110, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b1, 1'b1, 32'h18010001);
        end_session();
        req(S_WRAP, 1); req(S_COUNT, 2); req(S_ERR, 0);
        @(posedge clk); #1;

        // reset mid-session aborts
        start_session(8'h40);
        send(6'b001010, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0007, 26'd0, 1'b0, 1'b1, 32'h28220007);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req(S_WE, 0); req(S_BUSY, 0); req(S_COUNT, 0); req(S_READY, 0); req(S_DONE, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            req(S_DONE, 0); req(S_WE, 0);
        end

        // start while busy is ignored
        start_session(8'h50);
        start = 1'b1;
        start_addr = 8'h80;
        send(6'b000010, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b1, 1'b1, 32'h08850004);
        start = 1'b0;
        end_session();
        req(S_COUNT, 1);
        @(posedge clk); #1;

        // illegal last bundle still ends the session
        start_session(8'h60);
        send(6'h3E, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'd0, 1'b1, 1'b0, 32'd0);
        end_session();
        req(S_ERR, 1); req(S_ERROP, 32'h3E); req(S_COUNT, 0);
        @(posedge clk); #1;

        // jump target beyond memory
        start_session(8'h70);
`ifdef ENC_JUMP_CHECK_EN
        send(6'b000100, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h100, 1'b1, 1'b0, 32'd0);
        end_session();
        req(S_ERR, 1); req(S_ERROP, 32'h04); req(S_COUNT, 0);
`else
        send(6'b000100, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h100, 1'b1, 1'b1, 32'h10000100);
        end_session();
        req(S_ERR, 0); req(S_COUNT, 1);
`endif
        repeat (2) @(posedge clk);
        #1 req(S_SBQ, 0);
        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
